// File: rtl/axi4_slave_pkg.sv
// Shared definitions for the AXI4 slave memory.
// Holds the response and burst codes, the write/read FSM state types and
// a constant clog2 helper used to size address fields.
package axi4_slave_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_DATA
    } rd_state_t;

    // Ceiling log2 for elaboration-time sizing; clog2(1) is 0.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result++;
            rem = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/axi4_slave_mem_ram.sv
// DEPTH x DATA_WIDTH storage with one write port and one synchronous read
// port. A read and a write to the same word at the same edge return the old
// contents (read-before-write). The array is never reset.
// Ports: clk; we/waddr/wdata write port; re/raddr request a read whose
// result appears on rdata after the edge and is held while re is low.
module axi4_slave_mem_ram import axi4_slave_pkg::*; #(
    parameter int DEPTH      = 1024,
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_BITS  = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_BITS-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_BITS-1:0]  raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Both ports sample the array at the same edge, so a colliding read sees
    // the value from before the write lands.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/axi4_slave_mem.sv
// Parametrised AXI4 slave memory, one outstanding transaction per direction.
// INCR bursts up to 256 beats; SLVERR for bad size/burst/wlast, DECERR for
// beats outside the window [BASE_ADDR, BASE_ADDR + DEPTH words).
// Ports: clk, rst (async active-high); AW/W/B write channels and AR/R read
// channels, all with the *_s_inf suffix.
module axi4_slave_mem import axi4_slave_pkg::*; #(
    parameter int                    ID_WIDTH   = 4,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 128,
    parameter int                    DEPTH      = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h0001_0000,
    parameter int                    RD_LAT     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_WIDTH-1:0]   awid_s_inf,
    input  logic [ADDR_WIDTH-1:0] awaddr_s_inf,
    input  logic [7:0]            awlen_s_inf,
    input  logic [2:0]            awsize_s_inf,
    input  logic [1:0]            awburst_s_inf,
    input  logic                  awvalid_s_inf,
    output logic                  awready_s_inf,
    input  logic [DATA_WIDTH-1:0] wdata_s_inf,
    input  logic                  wlast_s_inf,
    input  logic                  wvalid_s_inf,
    output logic                  wready_s_inf,
    output logic [ID_WIDTH-1:0]   bid_s_inf,
    output logic [1:0]            bresp_s_inf,
    output logic                  bvalid_s_inf,
    input  logic                  bready_s_inf,
    input  logic [ID_WIDTH-1:0]   arid_s_inf,
    input  logic [ADDR_WIDTH-1:0] araddr_s_inf,
    input  logic [7:0]            arlen_s_inf,
    input  logic [2:0]            arsize_s_inf,
    input  logic [1:0]            arburst_s_inf,
    input  logic                  arvalid_s_inf,
    output logic                  arready_s_inf,
    output logic [ID_WIDTH-1:0]   rid_s_inf,
    output logic [DATA_WIDTH-1:0] rdata_s_inf,
    output logic [1:0]            rresp_s_inf,
    output logic                  rlast_s_inf,
    output logic                  rvalid_s_inf,
    input  logic                  rready_s_inf
);

    localparam int                SZ      = clog2(DATA_WIDTH / 8);
    localparam int                IW      = clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_X = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [3:0]        LAT_END = 4'(RD_LAT - 2);

    // Word index relative to BASE_ADDR, one bit wider than the address so
    // adding a beat offset never wraps back into range.
    function automatic logic [ADDR_WIDTH:0] word_index(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] off;
        off = addr - BASE_ADDR;
        return {1'b0, off >> SZ};
    endfunction

    wr_state_t w_state, w_next;
    rd_state_t r_state, r_next;
    logic      live;

    logic [ID_WIDTH-1:0]   w_id;
    logic [ADDR_WIDTH:0]   w_base, w_idx;
    logic [7:0]            w_len;
    logic [8:0]            w_cnt;
    logic                  w_below, w_fmt_err, w_dec, w_last_err;
    logic                  aw_hs, w_hs, w_oor, w_final, ram_we;

    logic [ID_WIDTH-1:0]   r_id;
    logic [ADDR_WIDTH:0]   r_base, r_idx, ar_idx;
    logic [7:0]            r_len;
    logic [8:0]            r_cnt;
    logic [3:0]            lat_cnt;
    logic                  r_below, r_fmt_err;
    logic                  ar_hs, r_hs, r_oor, r_final, ram_re;
    logic [IW-1:0]         ram_raddr;
    logic [DATA_WIDTH-1:0] ram_q;

    assign aw_hs   = awvalid_s_inf && awready_s_inf;
    assign w_hs    = wvalid_s_inf && wready_s_inf;
    assign w_idx   = w_base + (ADDR_WIDTH + 1)'(w_cnt);
    assign w_oor   = w_below || (w_idx >= DEPTH_X);
    assign w_final = (w_cnt == {1'b0, w_len});
    assign ram_we  = w_hs && !w_fmt_err && !w_oor;

    assign ar_hs   = arvalid_s_inf && arready_s_inf;
    assign r_hs    = rvalid_s_inf && rready_s_inf;
    assign ar_idx  = word_index(araddr_s_inf);
    assign r_idx   = r_base + (ADDR_WIDTH + 1)'(r_cnt);
    assign r_oor   = r_below || (r_idx >= DEPTH_X);
    assign r_final = (r_cnt == {1'b0, r_len});

    // The first beat is fetched at the AR handshake and each later beat at
    // the handshake of the one before it, so the RAM output stays put while
    // the master stalls or while the latency counter runs.
    assign ram_re    = ar_hs || (r_hs && !r_final);
    assign ram_raddr = (r_state == R_IDLE) ? ar_idx[IW-1:0] : (r_idx[IW-1:0] + IW'(1));

    assign bid_s_inf   = w_id;
    assign rid_s_inf   = r_id;
    assign rlast_s_inf = rvalid_s_inf && r_final;
    assign rresp_s_inf = !rvalid_s_inf ? RESP_OKAY :
                         r_oor         ? RESP_DECERR :
                         r_fmt_err     ? RESP_SLVERR : RESP_OKAY;
    assign rdata_s_inf = (rvalid_s_inf && (rresp_s_inf == RESP_OKAY)) ? ram_q : '0;

    // Holds both address-ready outputs low through reset and for the first
    // edge after it, so they rise one cycle after rst falls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live <= 1'b0;
        end else begin
            live <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    // Write channel sequencing and the single burst-wide B response.
    always_comb begin
        w_next        = w_state;
        awready_s_inf = 1'b0;
        wready_s_inf  = 1'b0;
        bvalid_s_inf  = 1'b0;
        bresp_s_inf   = RESP_OKAY;
        case (w_state)
            W_IDLE: begin
                awready_s_inf = live;
                if (awvalid_s_inf && live) begin
                    w_next = W_DATA;
                end
            end
            W_DATA: begin
                wready_s_inf = 1'b1;
                if (wvalid_s_inf && w_final) begin
                    w_next = W_RESP;
                end
            end
            W_RESP: begin
                bvalid_s_inf = 1'b1;
                bresp_s_inf  = w_dec ? RESP_DECERR :
                               (w_fmt_err || w_last_err) ? RESP_SLVERR : RESP_OKAY;
                if (bready_s_inf) begin
                    w_next = W_IDLE;
                end
            end
            default: w_next = W_IDLE;
        endcase
    end

    // Read channel sequencing: optional latency wait, then one beat per
    // R handshake until the last.
    always_comb begin
        r_next        = r_state;
        arready_s_inf = 1'b0;
        rvalid_s_inf  = 1'b0;
        case (r_state)
            R_IDLE: begin
                arready_s_inf = live;
                if (arvalid_s_inf && live) begin
                    r_next = (RD_LAT == 1) ? R_DATA : R_WAIT;
                end
            end
            R_WAIT: begin
                if (lat_cnt == LAT_END) begin
                    r_next = R_DATA;
                end
            end
            R_DATA: begin
                rvalid_s_inf = 1'b1;
                if (rready_s_inf && r_final) begin
                    r_next = R_IDLE;
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    // Write burst context; error flags accumulate over the burst so the
    // response reports the worst condition seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_id       <= '0;
            w_base     <= '0;
            w_len      <= '0;
            w_cnt      <= '0;
            w_below    <= 1'b0;
            w_fmt_err  <= 1'b0;
            w_dec      <= 1'b0;
            w_last_err <= 1'b0;
        end else if (aw_hs) begin
            w_id       <= awid_s_inf;
            w_base     <= word_index(awaddr_s_inf);
            w_len      <= awlen_s_inf;
            w_cnt      <= '0;
            w_below    <= (awaddr_s_inf < BASE_ADDR);
            w_fmt_err  <= (awsize_s_inf != 3'(SZ)) || (awburst_s_inf != BURST_INCR);
            w_dec      <= 1'b0;
            w_last_err <= 1'b0;
        end else if (w_hs) begin
            w_cnt      <= w_cnt + 9'd1;
            w_dec      <= w_dec | w_oor;
            w_last_err <= w_last_err | (wlast_s_inf != w_final);
        end
    end

    // Read burst context plus the latency counter used in R_WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_id      <= '0;
            r_base    <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_below   <= 1'b0;
            r_fmt_err <= 1'b0;
            lat_cnt   <= '0;
        end else if (ar_hs) begin
            r_id      <= arid_s_inf;
            r_base    <= ar_idx;
            r_len     <= arlen_s_inf;
            r_cnt     <= '0;
            r_below   <= (araddr_s_inf < BASE_ADDR);
            r_fmt_err <= (arsize_s_inf != 3'(SZ)) || (arburst_s_inf != BURST_INCR);
            lat_cnt   <= '0;
        end else begin
            if (r_state == R_WAIT) begin
                lat_cnt <= lat_cnt + 4'd1;
            end
            if (r_hs && !r_final) begin
                r_cnt <= r_cnt + 9'd1;
            end
        end
    end

    axi4_slave_mem_ram #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_BITS  (IW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (w_idx[IW-1:0]),
        .wdata (wdata_s_inf),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_q)
    );

endmodule

// File: tb/tb_axi4_slave_mem.sv
// Self-checking bench for axi4_slave_mem with default parameters.
// Keeps a word-level reference memory and derives every expected response
// and data value from the addressing and error rules.
module tb_axi4_slave_mem;

    localparam logic [31:0] BASE  = 32'h0001_0000;
    localparam int          DEPTH = 1024;

    logic         clk, rst;
    logic [3:0]   awid, bid, arid, rid;
    logic [31:0]  awaddr, araddr;
    logic [7:0]   awlen, arlen;
    logic [2:0]   awsize, arsize;
    logic [1:0]   awburst, arburst, bresp, rresp;
    logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rlast, rvalid, rready;
    logic [127:0] wdata, rdata;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [127:0] mem_m [DEPTH];
    logic [127:0] wq [$];
    logic [127:0] rq_data [$];
    logic [1:0]   rq_resp [$];
    logic         rq_last [$];
    logic [1:0]   b_resp_seen;
    logic [3:0]   b_id_seen, r_id_seen;
    int           lat_seen, stab_err;

    axi4_slave_mem dut (
        .clk(clk), .rst(rst),
        .awid_s_inf(awid), .awaddr_s_inf(awaddr), .awlen_s_inf(awlen),
        .awsize_s_inf(awsize), .awburst_s_inf(awburst),
        .awvalid_s_inf(awvalid), .awready_s_inf(awready),
        .wdata_s_inf(wdata), .wlast_s_inf(wlast),
        .wvalid_s_inf(wvalid), .wready_s_inf(wready),
        .bid_s_inf(bid), .bresp_s_inf(bresp),
        .bvalid_s_inf(bvalid), .bready_s_inf(bready),
        .arid_s_inf(arid), .araddr_s_inf(araddr), .arlen_s_inf(arlen),
        .arsize_s_inf(arsize), .arburst_s_inf(arburst),
        .arvalid_s_inf(arvalid), .arready_s_inf(arready),
        .rid_s_inf(rid), .rdata_s_inf(rdata), .rresp_s_inf(rresp),
        .rlast_s_inf(rlast), .rvalid_s_inf(rvalid), .rready_s_inf(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    // Reference rules: response of beat k of a burst, ignoring wlast.
    function automatic logic [1:0] beat_resp(logic [31:0] addr, logic [2:0] size,
                                             logic [1:0] burst, int k);
        longint off;
        if (addr < BASE) return 2'b11;
        off = longint'(addr) - longint'(BASE);
        if (off / 16 + k >= DEPTH) return 2'b11;
        if (size != 3'd4 || burst != 2'b01) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [1:0] exp_bresp(logic [31:0] addr, logic [7:0] len,
                                             logic [2:0] size, logic [1:0] burst, int flip);
        logic [1:0] r, b;
        r = 2'b00;
        for (int k = 0; k <= int'(len); k++) begin
            b = beat_resp(addr, size, burst, k);
            if (b > r) r = b;
        end
        if (flip >= 0 && flip <= int'(len) && r < 2'b10) r = 2'b10;
        return r;
    endfunction

    function automatic int widx(logic [31:0] addr);
        return int'((longint'(addr) - longint'(BASE)) / 16);
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Drives one write burst from wq; flip inverts wlast on that beat index.
    task automatic do_write(input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input int flip, input logic [3:0] id);
        int n;
        @(negedge clk);
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
        awvalid = 1'b1;
        n = 0;
        while (!awready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) begin
            total_cnt++;
            $display("[TB] FAIL aw_timeout awready=%0b required=1", awready);
        end
        @(posedge clk); @(negedge clk);
        awvalid = 1'b0;
        for (int k = 0; k <= int'(len); k++) begin
            wdata = wq[k];
            wlast = (k == int'(len)) ^ (k == flip);
            wvalid = 1'b1;
            n = 0;
            while (!wready && n < 100) begin @(negedge clk); n++; end
            if (n >= 100) begin
                total_cnt++;
                $display("[TB] FAIL w_timeout beat=%0d wready=%0b required=1", k, wready);
            end
            @(posedge clk); @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        bready = 1'b1;
        n = 0;
        while (!bvalid && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) begin
            total_cnt++;
            $display("[TB] FAIL b_timeout bvalid=%0b required=1", bvalid);
        end
        b_resp_seen = bresp;
        b_id_seen   = bid;
        @(posedge clk); @(negedge clk);
        bready = 1'b0;
        for (int k = 0; k <= int'(len); k++) begin
            if (beat_resp(addr, size, burst, k) == 2'b00) mem_m[widx(addr) + k] = wq[k];
        end
    endtask

    // Drives one read burst and collects beats; pat gives rready per cycle.
    task automatic do_read(input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input logic [3:0] pat, input logic [3:0] id);
        int n, lat, cyc;
        logic have_prev, pl;
        logic [127:0] pd;
        logic [1:0] pr;
        rq_data.delete(); rq_resp.delete(); rq_last.delete();
        stab_err = 0; have_prev = 1'b0; pd = '0; pr = '0; pl = 1'b0;
        @(negedge clk);
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
        arvalid = 1'b1; rready = 1'b0;
        n = 0;
        while (!arready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) begin
            total_cnt++;
            $display("[TB] FAIL ar_timeout arready=%0b required=1", arready);
        end
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        arvalid = 1'b0;
        while (!rvalid && lat < 50) begin @(posedge clk); lat++; @(negedge clk); end
        lat_seen = lat;
        cyc = 0;
        while (rq_data.size() < int'(len) + 1 && cyc < 3000) begin
            if (have_prev) begin
                if (!rvalid || rdata !== pd || rresp !== pr || rlast !== pl) stab_err++;
                have_prev = 1'b0;
            end
            rready = pat[cyc % 4];
            if (rvalid) begin
                if (rready) begin
                    if (rq_data.size() == 0) r_id_seen = rid;
                    rq_data.push_back(rdata); rq_resp.push_back(rresp); rq_last.push_back(rlast);
                end else begin
                    pd = rdata; pr = rresp; pl = rlast; have_prev = 1'b1;
                end
            end
            @(posedge clk); @(negedge clk);
            cyc++;
        end
        rready = 1'b0;
        if (cyc >= 3000) begin
            total_cnt++;
            $display("[TB] FAIL r_timeout beats=%0d required=%0d", rq_data.size(), int'(len) + 1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({awready, arready, bvalid, rvalid, rlast} !== 5'b0)
            $display("[TB] FAIL reset_ctrl got %b required 00000", {awready, arready, bvalid, rvalid, rlast});
        else pass_cnt++;
        total_cnt++;
        if ({rdata, rresp, bresp} !== '0) $display("[TB] FAIL reset_data got %h required 0", rdata);
        else pass_cnt++;
        rst = 1'b0;
        #1;
        total_cnt++;
        if (awready !== 1'b0) $display("[TB] FAIL release_awready_early got %b required 0", awready);
        else pass_cnt++;
        @(posedge clk); @(negedge clk);
        total_cnt++;
        if ({awready, arready} !== 2'b11) $display("[TB] FAIL release_ready got %b required 11", {awready, arready});
        else pass_cnt++;
    endtask

    task automatic test_fill();
        int bad;
        for (int blk = 0; blk < 4; blk++) begin
            wq.delete();
            for (int k = 0; k < 256; k++) wq.push_back(rnd128());
            do_write(BASE + 32'(blk * 4096), 8'd255, 3'd4, 2'b01, -1, 4'(blk));
            total_cnt++;
            if (b_resp_seen !== 2'b00) $display("[TB] FAIL fill_bresp blk=%0d got %b required 00", blk, b_resp_seen);
            else pass_cnt++;
        end
        do_read(BASE + 32'd4096, 8'd255, 3'd4, 2'b01, 4'b1111, 4'd9);
        bad = 0;
        for (int k = 0; k < 256; k++)
            if (rq_data[k] !== mem_m[256 + k] || rq_resp[k] !== 2'b00 || rq_last[k] !== (k == 255)) bad++;
        total_cnt++;
        if (bad != 0 || rq_data.size() != 256)
            $display("[TB] FAIL fill_readback bad_beats=%0d beats=%0d required 0/256", bad, rq_data.size());
        else pass_cnt++;
    endtask

    task automatic test_basic();
        wq.delete();
        wq.push_back(128'h11); wq.push_back(128'h22); wq.push_back(128'h33); wq.push_back(128'h44);
        do_write(BASE, 8'd3, 3'd4, 2'b01, -1, 4'd6);
        total_cnt++;
        if (b_resp_seen !== 2'b00 || b_id_seen !== 4'd6)
            $display("[TB] FAIL basic_b got resp=%b id=%0d required 00/6", b_resp_seen, b_id_seen);
        else pass_cnt++;
        do_read(BASE, 8'd3, 3'd4, 2'b01, 4'b1111, 4'd3);
        for (int k = 0; k < 4; k++) begin
            total_cnt++;
            if (rq_data[k] !== 128'(8'h11 * (k + 1)) || rq_resp[k] !== 2'b00 || rq_last[k] !== (k == 3))
                $display("[TB] FAIL basic_beat%0d got %h/%b/%b required %h/00/%b",
                         k, rq_data[k], rq_resp[k], rq_last[k], 128'(8'h11 * (k + 1)), k == 3);
            else pass_cnt++;
        end
        total_cnt++;
        if (lat_seen != 2 || r_id_seen !== 4'd3)
            $display("[TB] FAIL basic_latency got lat=%0d rid=%0d required 2/3", lat_seen, r_id_seen);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        wq.delete();
        for (int k = 0; k < 8; k++) wq.push_back(rnd128());
        do_write(BASE + 32'd1600, 8'd7, 3'd4, 2'b01, -1, 4'd1);
        do_read(BASE + 32'd1600, 8'd7, 3'd4, 2'b01, 4'b1001, 4'd2);
        total_cnt++;
        if (stab_err != 0 || rq_data.size() != 8)
            $display("[TB] FAIL bp_stability unstable=%0d beats=%0d required 0/8", stab_err, rq_data.size());
        else pass_cnt++;
        for (int k = 0; k < 8; k++) begin
            total_cnt++;
            if (rq_data[k] !== mem_m[100 + k] || rq_last[k] !== (k == 7))
                $display("[TB] FAIL bp_beat%0d got %h required %h", k, rq_data[k], mem_m[100 + k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_cross_top();
        logic [31:0] a;
        logic [1:0] er;
        logic [127:0] ed;
        a = BASE + 32'(1022 * 16);
        wq.delete();
        for (int k = 0; k < 4; k++) wq.push_back(rnd128());
        do_write(a, 8'd3, 3'd4, 2'b01, -1, 4'd4);
        total_cnt++;
        if (b_resp_seen !== exp_bresp(a, 8'd3, 3'd4, 2'b01, -1))
            $display("[TB] FAIL top_bresp got %b required %b", b_resp_seen, exp_bresp(a, 8'd3, 3'd4, 2'b01, -1));
        else pass_cnt++;
        do_read(a, 8'd3, 3'd4, 2'b01, 4'b1111, 4'd4);
        for (int k = 0; k < 4; k++) begin
            er = beat_resp(a, 3'd4, 2'b01, k);
            ed = (er == 2'b00) ? mem_m[1022 + k] : '0;
            total_cnt++;
            if (rq_data[k] !== ed || rq_resp[k] !== er || rq_last[k] !== (k == 3))
                $display("[TB] FAIL top_beat%0d got %h/%b required %h/%b", k, rq_data[k], rq_resp[k], ed, er);
            else pass_cnt++;
        end
    endtask

    task automatic test_slverr();
        logic [31:0] a;
        wq.delete();
        wq.push_back(rnd128());
        a = BASE + 32'd160;
        do_write(a, 8'd0, 3'd2, 2'b01, -1, 4'd5);
        total_cnt++;
        if (b_resp_seen !== 2'b10) $display("[TB] FAIL size_bresp got %b required 10", b_resp_seen);
        else pass_cnt++;
        do_read(a, 8'd0, 3'd4, 2'b01, 4'b1111, 4'd5);
        total_cnt++;
        if (rq_data[0] !== mem_m[10]) $display("[TB] FAIL size_unchanged got %h required %h", rq_data[0], mem_m[10]);
        else pass_cnt++;
        wq.delete();
        for (int k = 0; k < 4; k++) wq.push_back(rnd128());
        a = BASE + 32'd320;
        do_write(a, 8'd3, 3'd4, 2'b01, 1, 4'd7);
        total_cnt++;
        if (b_resp_seen !== 2'b10) $display("[TB] FAIL wlast_bresp got %b required 10", b_resp_seen);
        else pass_cnt++;
        do_read(a, 8'd3, 3'd4, 2'b01, 4'b1111, 4'd7);
        for (int k = 0; k < 4; k++) begin
            total_cnt++;
            if (rq_data[k] !== wq[k]) $display("[TB] FAIL wlast_written%0d got %h required %h", k, rq_data[k], wq[k]);
            else pass_cnt++;
        end
        do_read(BASE + 32'd800, 8'd2, 3'd4, 2'b10, 4'b1111, 4'd8);
        for (int k = 0; k < 3; k++) begin
            total_cnt++;
            if (rq_data[k] !== '0 || rq_resp[k] !== 2'b10)
                $display("[TB] FAIL burst_err_beat%0d got %h/%b required 0/10", k, rq_data[k], rq_resp[k]);
            else pass_cnt++;
        end
        do_read(32'h0000_0100, 8'd1, 3'd4, 2'b01, 4'b1111, 4'd8);
        for (int k = 0; k < 2; k++) begin
            total_cnt++;
            if (rq_data[k] !== '0 || rq_resp[k] !== 2'b11)
                $display("[TB] FAIL below_base_beat%0d got %h/%b required 0/11", k, rq_data[k], rq_resp[k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_concurrent();
        int n;
        logic [127:0] got;
        wq.delete();
        wq.push_back(128'hAA);
        do_write(BASE + 32'd80, 8'd0, 3'd4, 2'b01, -1, 4'd2);
        @(negedge clk);
        awaddr = BASE + 32'd80; awlen = 8'd0; awsize = 3'd4; awburst = 2'b01; awvalid = 1'b1;
        n = 0;
        while (!awready && n < 100) begin @(negedge clk); n++; end
        @(posedge clk); @(negedge clk);
        awvalid = 1'b0;
        wdata = 128'hBB; wlast = 1'b1; wvalid = 1'b1;
        araddr = BASE + 32'd80; arlen = 8'd0; arsize = 3'd4; arburst = 2'b01; arvalid = 1'b1;
        n = 0;
        while (!(arready && wready) && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) begin
            total_cnt++;
            $display("[TB] FAIL concurrent_timeout ready=%b required 11", {arready, wready});
        end
        @(posedge clk); @(negedge clk);
        wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0; rready = 1'b1;
        n = 0;
        while (!rvalid && n < 100) begin @(negedge clk); n++; end
        got = rdata;
        @(posedge clk); @(negedge clk);
        rready = 1'b0; bready = 1'b1;
        n = 0;
        while (!bvalid && n < 100) begin @(negedge clk); n++; end
        @(posedge clk); @(negedge clk);
        bready = 1'b0;
        mem_m[5] = 128'hBB;
        total_cnt++;
        if (got !== 128'hAA) $display("[TB] FAIL rbw_old got %h required aa", got);
        else pass_cnt++;
        do_read(BASE + 32'd80, 8'd0, 3'd4, 2'b01, 4'b1111, 4'd2);
        total_cnt++;
        if (rq_data[0] !== 128'hBB) $display("[TB] FAIL rbw_new got %h required bb", rq_data[0]);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [7:0] len;
        logic [1:0] er;
        logic [127:0] ed;
        int word;
        for (int it = 0; it < 8; it++) begin
            word = $urandom_range(0, 1016);
            len = 8'($urandom_range(0, 7));
            a = BASE + 32'(word * 16);
            wq.delete();
            for (int k = 0; k <= int'(len); k++) wq.push_back(rnd128());
            do_write(a, len, 3'd4, (it == 3) ? 2'b00 : 2'b01, -1, 4'(it));
            total_cnt++;
            if (b_resp_seen !== exp_bresp(a, len, 3'd4, (it == 3) ? 2'b00 : 2'b01, -1))
                $display("[TB] FAIL rand%0d_bresp got %b", it, b_resp_seen);
            else pass_cnt++;
            do_read(a, len, 3'd4, 2'b01, 4'($urandom_range(1, 15)), 4'(it));
            for (int k = 0; k <= int'(len); k++) begin
                er = beat_resp(a, 3'd4, 2'b01, k);
                ed = (er == 2'b00) ? mem_m[word + k] : '0;
                total_cnt++;
                if (rq_data[k] !== ed || rq_resp[k] !== er || rq_last[k] !== (k == int'(len)))
                    $display("[TB] FAIL rand%0d_beat%0d got %h/%b/%b required %h/%b/%b",
                             it, k, rq_data[k], rq_resp[k], rq_last[k], ed, er, k == int'(len));
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        int n, got;
        wq.delete();
        for (int k = 0; k < 8; k++) wq.push_back(rnd128());
        do_write(BASE + 32'd3200, 8'd7, 3'd4, 2'b01, -1, 4'd3);
        @(negedge clk);
        araddr = BASE + 32'd3200; arlen = 8'd7; arsize = 3'd4; arburst = 2'b01; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 100) begin @(negedge clk); n++; end
        @(posedge clk); @(negedge clk);
        arvalid = 1'b0; rready = 1'b1;
        got = 0; n = 0;
        while (got < 3 && n < 100) begin
            @(posedge clk); @(negedge clk);
            n++;
            if (rvalid) got++;
        end
        rready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({rvalid, arready, awready} !== 3'b000)
            $display("[TB] FAIL midrst_outputs got %b required 000", {rvalid, arready, awready});
        else pass_cnt++;
        rst = 1'b0;
        #1;
        total_cnt++;
        if (arready !== 1'b0) $display("[TB] FAIL midrst_arready_early got %b required 0", arready);
        else pass_cnt++;
        @(posedge clk); @(negedge clk);
        total_cnt++;
        if ({arready, rvalid} !== 2'b10) $display("[TB] FAIL midrst_release got %b required 10", {arready, rvalid});
        else pass_cnt++;
        do_read(BASE + 32'd3200, 8'd7, 3'd4, 2'b01, 4'b1111, 4'd3);
        for (int k = 0; k < 8; k++) begin
            total_cnt++;
            if (rq_data[k] !== mem_m[200 + k])
                $display("[TB] FAIL midrst_intact%0d got %h required %h", k, rq_data[k], mem_m[200 + k]);
            else pass_cnt++;
        end
    endtask

    initial begin
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        rready = 1'b0;
        test_reset();
        test_fill();
        test_basic();
        test_backpressure();
        test_cross_top();
        test_slverr();
        test_concurrent();
        test_random();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
